// File: rtl/panel_link_decoder.sv
// Receive-side decoder and monitor for the LED panel link (LP_CLK/LATCH/NOE/ROW/SDI).
// Define PANEL_LINK_CHECK_EN to build the sticky protocol checker driving proto_err.
module panel_link_decoder #(
  parameter int unsigned NUM_COLS = 64,
  parameter int unsigned LANES    = 3,
  parameter int unsigned ON_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_en,
  input  logic                      lp_clk,
  input  logic                      latch,
  input  logic                      noe,
  input  logic [4:0]                row,
  input  logic [LANES-1:0]          sdi,
  output logic [LANES*NUM_COLS-1:0] row_data,
  output logic                      data_latched,
  output logic                      cfg1_wr,
  output logic                      cfg2_wr,
  output logic [LANES*16-1:0]       cfg_data,
  output logic                      bad_cmd,
  output logic                      on_valid,
  output logic [ON_CNT_W-1:0]       on_time,
  output logic [4:0]                on_row,
  output logic                      proto_err
);

  localparam int unsigned SyncW = 8 + LANES;
  // Bit 2 is noe, which idles high.
  localparam logic [SyncW-1:0] SyncRst = SyncW'(4);

  logic [SyncW-1:0] sync1_q, sync2_q;
  logic [2:0]       prev_q;
  logic             lp_s, latch_s, noe_s;
  logic [4:0]       row_s;
  logic [LANES-1:0] sdi_s;
  logic             lp_rise, latch_rise, latch_fall, noe_rise, noe_fall;

  assign lp_s    = sync2_q[0];
  assign latch_s = sync2_q[1];
  assign noe_s   = sync2_q[2];
  assign row_s   = sync2_q[7:3];
  assign sdi_s   = sync2_q[SyncW-1:8];

  assign lp_rise    = lp_s & ~prev_q[0];
  assign latch_rise = latch_s & ~prev_q[1];
  assign latch_fall = ~latch_s & prev_q[1];
  assign noe_rise   = noe_s & ~prev_q[2];
  assign noe_fall   = ~noe_s & prev_q[2];

  logic [LANES*NUM_COLS-1:0] shift_q, shift_d;
  logic [LANES*16-1:0]       cfg_sh_q, cfg_sh_d;
  logic [7:0]                shift_cnt_q, shift_cnt_d, shift_cnt_inc;
  logic [3:0]                le_cnt_q, le_cnt_d;
  logic [ON_CNT_W-1:0]       win_q, win_d;
  logic [LANES*NUM_COLS-1:0] row_data_q, row_data_d;
  logic [LANES*16-1:0]       cfg_data_q, cfg_data_d;
  logic                      data_latched_q, data_latched_d;
  logic                      cfg1_wr_q, cfg1_wr_d;
  logic                      cfg2_wr_q, cfg2_wr_d;
  logic                      bad_cmd_q, bad_cmd_d;
  logic                      on_valid_q, on_valid_d;
  logic [ON_CNT_W-1:0]       on_time_q, on_time_d;
  logic [4:0]                on_row_q, on_row_d;

  function automatic logic [NUM_COLS-1:0] shl_cols(input logic [NUM_COLS-1:0] v, input logic b);
    logic [NUM_COLS:0] t;
    t = {v, b};
    return t[NUM_COLS-1:0];
  endfunction

  always_comb begin
    shift_d       = shift_q;
    cfg_sh_d      = cfg_sh_q;
    shift_cnt_inc = shift_cnt_q;
    le_cnt_d      = latch_rise ? 4'd0 : le_cnt_q;
    if (lp_rise) begin
      for (int k = 0; k < LANES; k++) begin
        shift_d[k*NUM_COLS +: NUM_COLS] = shl_cols(shift_q[k*NUM_COLS +: NUM_COLS], sdi_s[k]);
        cfg_sh_d[k*16 +: 16]            = {cfg_sh_q[k*16 +: 15], sdi_s[k]};
      end
      shift_cnt_inc = (shift_cnt_q == 8'hFF) ? shift_cnt_q : shift_cnt_q + 8'd1;
      // prev_q[1] keeps an edge that coincides with the latch fall inside the LE window.
      if (latch_s || prev_q[1]) begin
        le_cnt_d = (le_cnt_d == 4'hF) ? le_cnt_d : le_cnt_d + 4'd1;
      end
    end

    shift_cnt_d    = shift_cnt_inc;
    row_data_d     = row_data_q;
    cfg_data_d     = cfg_data_q;
    data_latched_d = 1'b0;
    cfg1_wr_d      = 1'b0;
    cfg2_wr_d      = 1'b0;
    bad_cmd_d      = 1'b0;
    if (latch_fall) begin
      shift_cnt_d = 8'd0;
      case (le_cnt_d)
        4'd3: begin
          row_data_d     = shift_d;
          data_latched_d = 1'b1;
        end
        4'd11: begin
          cfg_data_d = cfg_sh_d;
          cfg1_wr_d  = 1'b1;
        end
        4'd12: begin
          cfg_data_d = cfg_sh_d;
          cfg2_wr_d  = 1'b1;
        end
        default: bad_cmd_d = 1'b1;
      endcase
    end

    win_d      = win_q;
    on_valid_d = 1'b0;
    on_time_d  = on_time_q;
    on_row_d   = on_row_q;
    if (noe_fall) begin
      win_d = '0;
    end else if (!noe_s && tick_en && (win_q != '1)) begin
      win_d = win_q + 1'b1;
    end
    if (noe_rise) begin
      on_time_d  = win_q;
      on_row_d   = row_s;
      on_valid_d = 1'b1;
      win_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= SyncRst;
      sync2_q        <= SyncRst;
      prev_q         <= 3'b100;
      shift_q        <= '0;
      cfg_sh_q       <= '0;
      shift_cnt_q    <= '0;
      le_cnt_q       <= '0;
      win_q          <= '0;
      row_data_q     <= '0;
      cfg_data_q     <= '0;
      data_latched_q <= 1'b0;
      cfg1_wr_q      <= 1'b0;
      cfg2_wr_q      <= 1'b0;
      bad_cmd_q      <= 1'b0;
      on_valid_q     <= 1'b0;
      on_time_q      <= '0;
      on_row_q       <= '0;
    end else begin
      sync1_q        <= {sdi, row, noe, latch, lp_clk};
      sync2_q        <= sync1_q;
      prev_q         <= {noe_s, latch_s, lp_s};
      shift_q        <= shift_d;
      cfg_sh_q       <= cfg_sh_d;
      shift_cnt_q    <= shift_cnt_d;
      le_cnt_q       <= le_cnt_d;
      win_q          <= win_d;
      row_data_q     <= row_data_d;
      cfg_data_q     <= cfg_data_d;
      data_latched_q <= data_latched_d;
      cfg1_wr_q      <= cfg1_wr_d;
      cfg2_wr_q      <= cfg2_wr_d;
      bad_cmd_q      <= bad_cmd_d;
      on_valid_q     <= on_valid_d;
      on_time_q      <= on_time_d;
      on_row_q       <= on_row_d;
    end
  end

`ifdef PANEL_LINK_CHECK_EN
  logic [4:0] row_prev_q;
  logic       proto_q, proto_d;

  always_comb begin
    proto_d = proto_q;
    if (data_latched_d && (shift_cnt_inc != 8'(NUM_COLS))) proto_d = 1'b1;
    if (bad_cmd_d)                                         proto_d = 1'b1;
    if (!noe_s && latch_s)                                 proto_d = 1'b1;
    if (!noe_s && (row_s != row_prev_q))                   proto_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_prev_q <= '0;
      proto_q    <= 1'b0;
    end else begin
      row_prev_q <= row_s;
      proto_q    <= proto_d;
    end
  end

  assign proto_err = proto_q;
`else
  assign proto_err = 1'b0;
`endif

  assign row_data     = row_data_q;
  assign data_latched = data_latched_q;
  assign cfg1_wr      = cfg1_wr_q;
  assign cfg2_wr      = cfg2_wr_q;
  assign cfg_data     = cfg_data_q;
  assign bad_cmd      = bad_cmd_q;
  assign on_valid     = on_valid_q;
  assign on_time      = on_time_q;
  assign on_row       = on_row_q;

endmodule

// File: tb/tb_panel_link_decoder.sv
// Bench for panel_link_decoder: pin-level stimulus, event-queue reference model,
// per-cycle comparison of every output.
module tb_panel_link_decoder;

  localparam int unsigned NUM_COLS = 64;
  localparam int unsigned LANES    = 3;
  localparam int unsigned ON_CNT_W = 16;
  localparam int unsigned RdW      = LANES * NUM_COLS;
  localparam int unsigned CfgW     = LANES * 16;
`ifdef PANEL_LINK_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, tick_en, lp_clk, latch, noe;
  logic [4:0]          row;
  logic [LANES-1:0]    sdi;
  logic [RdW-1:0]      row_data;
  logic                data_latched, cfg1_wr, cfg2_wr, bad_cmd, on_valid, proto_err;
  logic [CfgW-1:0]     cfg_data;
  logic [ON_CNT_W-1:0] on_time;
  logic [4:0]          on_row;

  panel_link_decoder #(
    .NUM_COLS(NUM_COLS),
    .LANES   (LANES),
    .ON_CNT_W(ON_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .lp_clk      (lp_clk),
    .latch       (latch),
    .noe         (noe),
    .row         (row),
    .sdi         (sdi),
    .row_data    (row_data),
    .data_latched(data_latched),
    .cfg1_wr     (cfg1_wr),
    .cfg2_wr     (cfg2_wr),
    .cfg_data    (cfg_data),
    .bad_cmd     (bad_cmd),
    .on_valid    (on_valid),
    .on_time     (on_time),
    .on_row      (on_row),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // kind: 0 data latch, 1 cfg1, 2 cfg2, 3 bad, 4 window close, 5 protocol flag only
  typedef struct {
    int                  cyc;
    int                  kind;
    logic [RdW-1:0]      rd;
    logic [CfgW-1:0]     cfg;
    logic [ON_CNT_W-1:0] ot;
    logic [4:0]          orow;
    bit                  proto;
  } ev_t;
  ev_t evq[$];

  logic [NUM_COLS-1:0] m_shift [LANES];
  logic [15:0]         m_cfg   [LANES];
  int                  m_shcnt, m_le;
  logic [RdW-1:0]      exp_rd;
  logic [CfgW-1:0]     exp_cfg;
  logic [ON_CNT_W-1:0] exp_ot;
  logic [4:0]          exp_orow;
  bit                  exp_proto;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Outputs change 3 edges after the pin change is first sampled.
  always @(negedge clk) begin
    logic [4:0] ep;
    ev_t        e;
    if (rst) begin
      chk("reset_outs", {row_data, data_latched, cfg1_wr, cfg2_wr, cfg_data, bad_cmd,
                         on_valid, on_time, on_row, proto_err}, '0);
    end else begin
      ep = '0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          0: begin ep[4] = 1'b1; exp_rd = e.rd; end
          1: begin ep[3] = 1'b1; exp_cfg = e.cfg; end
          2: begin ep[2] = 1'b1; exp_cfg = e.cfg; end
          3: ep[1] = 1'b1;
          4: begin ep[0] = 1'b1; exp_ot = e.ot; exp_orow = e.orow; end
          default: ;
        endcase
        if (e.proto) exp_proto = 1'b1;
      end
      chk("pulses", {data_latched, cfg1_wr, cfg2_wr, bad_cmd, on_valid}, ep);
      chk("row_data", row_data, exp_rd);
      chk("cfg_data", cfg_data, exp_cfg);
      chk("on_time", on_time, exp_ot);
      chk("on_row", on_row, exp_orow);
      chk("proto_err", proto_err, exp_proto & ChkEn);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input ev_t e);
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].cyc > e.cyc) begin
        evq.insert(i, e);
        return;
      end
    end
    evq.push_back(e);
  endtask

  function automatic ev_t new_ev(input int kind);
    ev_t e;
    e.cyc   = cyc + 3;
    e.kind  = kind;
    e.rd    = '0;
    e.cfg   = '0;
    e.ot    = '0;
    e.orow  = '0;
    e.proto = 1'b0;
    return e;
  endfunction

  task automatic model_clear();
    evq.delete();
    for (int k = 0; k < LANES; k++) begin
      m_shift[k] = '0;
      m_cfg[k]   = '0;
    end
    m_shcnt   = 0;
    m_le      = 0;
    exp_rd    = '0;
    exp_cfg   = '0;
    exp_ot    = '0;
    exp_orow  = '0;
    exp_proto = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    wait_cyc(4);
    rst = 1'b0;
  endtask

  task automatic decode();
    ev_t e;
    case (m_le)
      3: begin
        e = new_ev(0);
        for (int k = 0; k < LANES; k++) e.rd[k*NUM_COLS +: NUM_COLS] = m_shift[k];
        e.proto = (m_shcnt != NUM_COLS);
      end
      11, 12: begin
        e = new_ev((m_le == 11) ? 1 : 2);
        for (int k = 0; k < LANES; k++) e.cfg[k*16 +: 16] = m_cfg[k];
      end
      default: begin
        e = new_ev(3);
        e.proto = 1'b1;
      end
    endcase
    m_shcnt = 0;
    push_ev(e);
  endtask

  task automatic lp_pulse(input logic [LANES-1:0] bits, input bit drop);
    sdi = bits;
    wait_cyc(3);
    for (int k = 0; k < LANES; k++) begin
      m_shift[k] = {m_shift[k][NUM_COLS-2:0], bits[k]};
      m_cfg[k]   = {m_cfg[k][14:0], bits[k]};
    end
    m_shcnt = (m_shcnt < 255) ? m_shcnt + 1 : 255;
    if (latch) m_le = (m_le < 15) ? m_le + 1 : 15;
    lp_clk = 1'b1;
    if (drop) begin
      decode();
      latch = 1'b0;
    end
    wait_cyc(3);
    lp_clk = 1'b0;
    if (drop) wait_cyc(4);
  endtask

  task automatic latch_up();
    latch = 1'b1;
    m_le  = 0;
    wait_cyc(3);
  endtask

  task automatic latch_down();
    decode();
    latch = 1'b0;
    wait_cyc(4);
  endtask

  // mode 0: constant cv on all lanes; 1: lane 0 ends with pat (MSB first); 2: random
  task automatic cmd(input int n_pre, input int n_le, input int mode, input logic [15:0] pat,
                     input logic [LANES-1:0] cv, input bit simul);
    int total;
    logic [LANES-1:0] b;
    total = n_pre + n_le;
    for (int j = 0; j < total; j++) begin
      if (j == n_pre) latch_up();
      case (mode)
        0: b = cv;
        1: begin
          b = LANES'($urandom);
          if (total - 1 - j < 16) b[0] = pat[total-1-j];
        end
        default: b = LANES'($urandom);
      endcase
      lp_pulse(b, simul && (j == total - 1));
    end
    if (n_le == 0) latch_up();
    if (!(simul && n_le > 0)) latch_down();
  endtask

  task automatic window(input logic [4:0] row_v, input int n, input bit rnd, input bit row_chg);
    int  cnt;
    ev_t e;
    cnt = 0;
    row = row_v;
    wait_cyc(4);
    noe = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < n; i++) begin
      tick_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tick_en) cnt++;
      if (row_chg && i == n / 2) begin
        row = row ^ 5'd17;
        e = new_ev(5);
        e.proto = 1'b1;
        push_ev(e);
      end
      wait_cyc(1);
    end
    tick_en = 1'b0;
    wait_cyc(4);
    e = new_ev(4);
    e.ot   = (cnt >= (1 << ON_CNT_W) - 1) ? '1 : ON_CNT_W'(cnt);
    e.orow = row;
    noe = 1'b1;
    push_ev(e);
    wait_cyc(4);
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    tick_en = 1'b0;
    lp_clk  = 1'b0;
    latch   = 1'b0;
    noe     = 1'b1;
    row     = '0;
    sdi     = '0;
    model_clear();
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(4);

    // Full row, constant lanes 1/0/1
    cmd(NUM_COLS - 3, 3, 0, 16'h0, 3'b101, 1'b0);
    chk("t1_row_data", row_data, {{NUM_COLS{1'b1}}, {NUM_COLS{1'b0}}, {NUM_COLS{1'b1}}});
    chk("t1_proto", proto_err, 1'b0);

    cmd(5, 11, 1, 16'hA5C3, '0, 1'b0);
    chk("t2_cfg1_lane0", cfg_data[15:0], 16'hA5C3);
    cmd(4, 12, 1, 16'h5A3C, '0, 1'b0);
    chk("t3_cfg2_lane0", cfg_data[15:0], 16'h5A3C);
    cmd(5, 7, 2, 16'h0, '0, 1'b0);
    chk("t3_bad_proto", proto_err, ChkEn);
    // Last LE edge coincides with the latch fall
    cmd(5, 11, 1, 16'h1234, '0, 1'b1);
    chk("t4_simul_cfg", cfg_data[15:0], 16'h1234);

    window(5'd5, 100, 1'b0, 1'b0);
    chk("win100_time", on_time, 16'd100);
    chk("win100_row", on_row, 5'd5);
    window(5'd9, 65540, 1'b0, 1'b0);
    chk("win_sat_time", on_time, 16'hFFFF);

    // Reset in the middle of an LE window
    latch_up();
    lp_pulse(3'b111, 1'b0);
    lp_pulse(3'b111, 1'b0);
    do_reset();
    wait_cyc(4);
    chk("rst_row_data", row_data, '0);
    latch_down();
    chk("rst_bad_proto", proto_err, ChkEn);

    // Short row, then row change during a window
    do_reset();
    wait_cyc(4);
    cmd(NUM_COLS - 4, 3, 2, 16'h0, '0, 1'b0);
    chk("short_proto", proto_err, ChkEn);
    window(5'd3, 40, 1'b1, 1'b1);

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 70)) : NUM_COLS;
          cmd(n - 3, 3, 2, 16'h0, '0, 1'($urandom_range(0, 1)));
        end
        1: cmd($urandom_range(0, 20), 11 + $urandom_range(0, 1), 2, 16'h0, '0,
               1'($urandom_range(0, 1)));
        2: cmd($urandom_range(0, 10), $urandom_range(0, 17), 2, 16'h0, '0, 1'b0);
        default: window(5'($urandom_range(0, 31)), $urandom_range(1, 300), 1'b1, 1'b0);
      endcase
    end

    wait_cyc(10);
    chk("ev_drain", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
